prbs_checker: RTL and testbench

- Receive-side counterpart of the team's LFSR pattern generator.
- Consumes the serial pseudo-random bit stream the generator emits and self-synchronises a local LFSR to it.
- Once locked, compares every received bit with the predicted bit, flags each mismatch and keeps a saturating error count.
- Sits at the far end of a link or loopback path as a BIST/link-integrity monitor.

---
 rtl/prbs_checker.sv | 130 +++++++++++++
 tb/tb_prbs_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS checker. It self-synchronises a local LFSR to a received serial stream.
// Once locked, it flags every bit that differs from the prediction and counts these errors.
module prbs_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
  parameter int               LOCK_CNT = 8,
  parameter int               LOSS_CNT = 4,
  parameter int               ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_i,
  input  logic             valid_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t             r_state, w_stateNext;
  logic [WIDTH-1:0]   r_ref, w_refNext;
  logic [FILL_W-1:0]  r_fillCnt, w_fillCntNext;
  logic [MATCH_W-1:0] r_matchCnt, w_matchCntNext;
  logic [LOSS_W-1:0]  r_lossCnt, w_lossCntNext;
  logic               r_err, w_errNext;
  logic [ERR_W-1:0]   r_errCnt, w_errCntNext;

  logic w_predict;
  logic w_mismatch;
  logic w_fillDone;
  logic w_refZero;
  logic w_errCntMax;

  assign w_predict   = ^(r_ref & TAPS);
  assign w_mismatch  = (data_i != w_predict);
  assign w_fillDone  = (r_fillCnt == FILL_W'(WIDTH));
  assign w_refZero   = (r_ref == '0);
  assign w_errCntMax = &r_errCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SEARCH;
      r_ref      <= '0;
      r_fillCnt  <= '0;
      r_matchCnt <= '0;
      r_lossCnt  <= '0;
      r_err      <= 1'b0;
      r_errCnt   <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_ref      <= w_refNext;
      r_fillCnt  <= w_fillCntNext;
      r_matchCnt <= w_matchCntNext;
      r_lossCnt  <= w_lossCntNext;
      r_err      <= w_errNext;
      r_errCnt   <= w_errCntNext;
    end
  end

  // SEARCH loads received bits. An all-zero reference never counts as a match,
  // so a dead line cannot lock. LOCKED free-runs on its own prediction.
  always_comb begin
    w_stateNext    = r_state;
    w_refNext      = r_ref;
    w_fillCntNext  = r_fillCnt;
    w_matchCntNext = r_matchCnt;
    w_lossCntNext  = r_lossCnt;
    w_errNext      = 1'b0;
    w_errCntNext   = r_errCnt;

    if (valid_i) begin
      case (r_state)
        SEARCH: begin
          w_refNext = {r_ref[WIDTH-2:0], data_i};
          if (!w_fillDone) begin
            w_fillCntNext = r_fillCnt + FILL_W'(1);
          end else if (w_refZero || w_mismatch) begin
            w_matchCntNext = '0;
          end else if (r_matchCnt == MATCH_W'(LOCK_CNT - 1)) begin
            w_stateNext    = LOCKED;
            w_matchCntNext = '0;
            w_lossCntNext  = '0;
          end else begin
            w_matchCntNext = r_matchCnt + MATCH_W'(1);
          end
        end
        LOCKED: begin
          w_refNext = {r_ref[WIDTH-2:0], w_predict};
          if (w_mismatch) begin
            w_errNext = 1'b1;
            if (!w_errCntMax) begin
              w_errCntNext = r_errCnt + ERR_W'(1);
            end
            if (r_lossCnt == LOSS_W'(LOSS_CNT - 1)) begin
              w_stateNext    = SEARCH;
              w_fillCntNext  = '0;
              w_matchCntNext = '0;
              w_lossCntNext  = '0;
            end else begin
              w_lossCntNext = r_lossCnt + LOSS_W'(1);
            end
          end else begin
            w_lossCntNext = '0;
          end
        end
        default: begin
          w_stateNext = SEARCH;
        end
      endcase
    end

    if (clr_i) begin
      w_errCntNext = '0;
    end
  end

  assign locked_o  = (r_state == LOCKED);
  assign err_o     = r_err;
  assign err_cnt_o = r_errCnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker. A spec-level model queues the expected outputs for each driven bit.
// Fixed-value checks pin the lock, error and clear timing.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_i;
  logic        valid_i;
  logic        clr_i;
  logic        locked_o;
  logic        err_o;
  logic [15:0] err_cnt_o;

  prbs_checker dut (
    .clk      (clk),
    .reset    (reset),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .clr_i    (clr_i),
    .locked_o (locked_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
  } expT;

  expT sbQ[$];

  int checkCount = 0;
  int passCount  = 0;

  logic [3:0] gState;
  int         gCount;

  logic [3:0] mRef;
  logic       mLocked;
  int         mFill, mMatch, mLoss;
  logic       mErr;
  int         mCnt;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  task automatic modelReset();
    mRef = 4'b0000; mLocked = 1'b0; mFill = 0; mMatch = 0; mLoss = 0; mErr = 1'b0; mCnt = 0;
  endtask

  // Generator: fb = s[3]^s[2], shifted into s[0], and fb is the emitted bit.
  task automatic genBit(output logic b);
    logic fb;
    fb = gState[3] ^ gState[2];
    gState = {gState[2:0], fb};
    gCount++;
    b = fb;
  endtask

  task automatic modelStep(input logic d, input logic v, input logic c);
    logic p;
    p = mRef[3] ^ mRef[2];
    mErr = 1'b0;
    if (v) begin
      if (!mLocked) begin
        if (mFill < 4) mFill++;
        else if (mRef == 4'b0000 || d != p) mMatch = 0;
        else begin
          mMatch++;
          if (mMatch == 8) begin mLocked = 1'b1; mMatch = 0; mLoss = 0; end
        end
        mRef = {mRef[2:0], d};
      end else begin
        if (d != p) begin
          mErr = 1'b1;
          if (mCnt < 65535) mCnt++;
          mLoss++;
          if (mLoss == 4) begin mLocked = 1'b0; mFill = 0; mMatch = 0; mLoss = 0; end
        end else mLoss = 0;
        mRef = {mRef[2:0], p};
      end
    end
    if (c) mCnt = 0;
  endtask

  task automatic applyStimulus(input logic d, input logic v, input logic c);
    expT e;
    data_i = d; valid_i = v; clr_i = c;
    modelStep(d, v, c);
    e.locked = mLocked; e.err = mErr; e.cnt = 16'(mCnt);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    checkOutput("sbLocked", 32'(locked_o), 32'(e.locked));
    checkOutput("sbErr", 32'(err_o), 32'(e.err));
    checkOutput("sbErrCnt", 32'(err_cnt_o), 32'(e.cnt));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic b;
    logic errSeen;
    int   relockAt;
    int   validCount;

    gState = 4'b0001; gCount = 0;
    modelReset();
    reset = 1'b1; data_i = 1'b0; valid_i = 1'b0; clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstLocked", 32'(locked_o), 32'd0);
    checkOutput("rstErr", 32'(err_o), 32'd0);
    checkOutput("rstErrCnt", 32'(err_cnt_o), 32'd0);
    reset = 1'b0;

    // Clean stream: lock at the 12th bit, no errors over 60 bits.
    errSeen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      genBit(b);
      applyStimulus(b, 1'b1, 1'b0);
      errSeen |= err_o;
      if (i == 11) checkOutput("lockBefore12", 32'(locked_o), 32'd0);
      if (i == 12) checkOutput("lockAt12", 32'(locked_o), 32'd1);
    end
    checkOutput("errCnt60", 32'(err_cnt_o), 32'd0);
    checkOutput("noErrClean", 32'(errSeen), 32'd0);

    // Single inverted bit: one pulse, no propagation.
    repeat (4) begin genBit(b); applyStimulus(b, 1'b1, 1'b0); end
    genBit(b);
    applyStimulus(~b, 1'b1, 1'b0);
    checkOutput("flipErrPulse", 32'(err_o), 32'd1);
    checkOutput("flipErrCnt", 32'(err_cnt_o), 32'd1);
    checkOutput("flipLocked", 32'(locked_o), 32'd1);
    genBit(b);
    applyStimulus(b, 1'b1, 1'b0);
    checkOutput("flipOnePulse", 32'(err_o), 32'd0);
    errSeen = 1'b0;
    repeat (15) begin genBit(b); applyStimulus(b, 1'b1, 1'b0); errSeen |= err_o; end
    checkOutput("flipNoProp", 32'(errSeen), 32'd0);
    checkOutput("flipCntHold", 32'(err_cnt_o), 32'd1);

    // Build err_cnt to 5, then clear in the same cycle as a mismatch.
    repeat (4) begin
      genBit(b); applyStimulus(~b, 1'b1, 1'b0);
      repeat (3) begin genBit(b); applyStimulus(b, 1'b1, 1'b0); end
    end
    checkOutput("errCnt5", 32'(err_cnt_o), 32'd5);
    genBit(b);
    applyStimulus(~b, 1'b1, 1'b1);
    checkOutput("clrErrPulse", 32'(err_o), 32'd1);
    checkOutput("clrErrCnt", 32'(err_cnt_o), 32'd0);
    checkOutput("clrLocked", 32'(locked_o), 32'd1);

    // Stuck-at-zero line covering the 1111 run of the stream.
    for (int i = 0; i < 15 && (gCount % 15) != 5; i++) begin
      genBit(b); applyStimulus(b, 1'b1, 1'b0);
    end
    checkOutput("zeroPhase", 32'(gCount % 15), 32'd5);
    for (int k = 0; k < 10; k++) begin
      genBit(b);
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (k == 4) checkOutput("zeroStillLocked", 32'(locked_o), 32'd1);
      if (k == 5) begin
        checkOutput("zeroLossLock", 32'(locked_o), 32'd0);
        checkOutput("zeroLastErr", 32'(err_o), 32'd1);
      end
    end
    checkOutput("zeroUnlocked", 32'(locked_o), 32'd0);
    checkOutput("zeroErrCnt", 32'(err_cnt_o), 32'd5);
    relockAt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (relockAt == 0) begin
        genBit(b);
        applyStimulus(b, 1'b1, 1'b0);
        if (locked_o) relockAt = i;
      end
    end
    checkOutput("zeroRelockBits", 32'(relockAt), 32'd12);

    // Asynchronous reset while locked, then relock with valid toggling.
    #2;
    reset = 1'b1;
    #2;
    checkOutput("midRstLocked", 32'(locked_o), 32'd0);
    checkOutput("midRstErrCnt", 32'(err_cnt_o), 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    validCount = 0; relockAt = 0; errSeen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (relockAt == 0) begin
        if (i % 2 == 0) begin
          genBit(b);
          applyStimulus(b, 1'b1, 1'b0);
          validCount++;
          if (locked_o) relockAt = validCount;
        end else begin
          applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        errSeen |= err_o;
      end
    end
    checkOutput("toggleRelockBits", 32'(relockAt), 32'd12);
    checkOutput("toggleNoErr", 32'(errSeen), 32'd0);
    checkOutput("toggleErrCnt", 32'(err_cnt_o), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
